// File: rtl/dlx_pipe_pkg.sv
// dlx_pipe_pkg: shared types and constants for the DLX pipeline control blocks.
package dlx_pipe_pkg;
   typedef enum logic [1:0] {F_RUN, F_PEND, F_ISSUE} fetch_state_t;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter stepping by +1 and/or +2 per cycle, clamped at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc1,
   input  logic         inc2,
   output logic [W-1:0] cnt
);
   logic [W:0]   sum;
   logic [W-1:0] cnt_nxt;
   always_comb begin
      sum     = {1'b0, cnt} + (W+1)'({inc2, inc1});
      cnt_nxt = sum[W] ? '1 : sum[W-1:0];
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt_nxt;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer arbitrating redirects against stalls and imem waits;
// redirects seen during an outstanding fetch are parked until the stale word is discarded.
module fetch_ctrl
   import dlx_pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             br_take_EX,
   input  logic [31:0]      br_target_EX,
   input  logic             jmp_ID,
   input  logic [31:0]      jmp_target_ID,
   input  logic             ld_use_stall,
   input  logic             i_ready,
   output logic             pc_cmd_EX,
   output logic             pc_cmd_ID,
   output logic [31:0]      pc_in_EX,
   output logic [31:0]      pc_in_ID,
   output logic             pc_hold,
   output logic             i_req,
   output logic             stall_IFID,
   output logic             flush_IFID,
   output logic             flush_IDEX,
   output logic [CNT_W-1:0] squash_cnt
);
   fetch_state_t state, state_nxt;
   logic [31:0]  pend_target, pend_nxt;
   logic         cmd_ex, cmd_id, hold, stall_ifid, fl_ifid, fl_idex, inc1, inc2;

   always_comb begin
      state_nxt  = state;
      pend_nxt   = pend_target;
      cmd_ex     = 1'b0;
      cmd_id     = 1'b0;
      hold       = 1'b0;
      stall_ifid = 1'b0;
      fl_ifid    = 1'b0;
      fl_idex    = 1'b0;
      inc1       = 1'b0;
      inc2       = 1'b0;
      case (state)
         F_RUN: begin
            if (br_take_EX) begin
               fl_ifid = 1'b1;
               fl_idex = 1'b1;
               inc2    = 1'b1;
               if (i_ready) cmd_ex = 1'b1;
               else begin
                  pend_nxt  = br_target_EX;
                  hold      = 1'b1;
                  state_nxt = F_PEND;
               end
            end else if (ld_use_stall) begin
               hold       = 1'b1;
               stall_ifid = 1'b1;
               fl_idex    = 1'b1;
            end else if (jmp_ID) begin
               fl_ifid = 1'b1;
               inc1    = 1'b1;
               if (i_ready) cmd_id = 1'b1;
               else begin
                  pend_nxt  = jmp_target_ID;
                  hold      = 1'b1;
                  state_nxt = F_PEND;
               end
            end else if (!i_ready) begin
               hold    = 1'b1;
               fl_ifid = 1'b1;
            end
         end
         F_PEND: begin
            hold    = 1'b1;
            fl_ifid = 1'b1;
            if (i_ready) begin
               inc1      = 1'b1;
               state_nxt = F_ISSUE;
            end
         end
         F_ISSUE: begin
            cmd_ex    = 1'b1;
            state_nxt = F_RUN;
         end
         default: state_nxt = F_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state       <= F_RUN;
         pend_target <= RESET_PC;
      end else begin
         state       <= state_nxt;
         pend_target <= pend_nxt;
      end

   // every output is forced low while reset is held, including the fetch request
   assign pc_cmd_EX  = reset_n & cmd_ex;
   assign pc_cmd_ID  = reset_n & cmd_id;
   assign pc_hold    = reset_n & hold;
   assign i_req      = reset_n;
   assign stall_IFID = reset_n & stall_ifid;
   assign flush_IFID = reset_n & fl_ifid;
   assign flush_IDEX = reset_n & fl_idex;
   assign pc_in_ID   = reset_n ? jmp_target_ID : '0;
   assign pc_in_EX   = !reset_n ? '0 : (state == F_ISSUE) ? pend_target : br_target_EX;

   sat_counter #(.W(CNT_W)) u_squash (
      .clk     (clk),
      .reset_n (reset_n),
      .inc1    (inc1),
      .inc2    (inc2),
      .cnt     (squash_cnt)
   );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenario bench for fetch_ctrl.
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        br_take_EX = 1'b0, jmp_ID = 1'b0, ld_use_stall = 1'b0, i_ready = 1'b1;
   logic [31:0] br_target_EX = '0, jmp_target_ID = '0;
   logic        pc_cmd_EX, pc_cmd_ID, pc_hold, i_req, stall_IFID, flush_IFID, flush_IDEX;
   logic [31:0] pc_in_EX, pc_in_ID;
   logic [15:0] squash_cnt;
   int          errors = 0;
   int          checks = 0;

   fetch_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .br_take_EX(br_take_EX), .br_target_EX(br_target_EX),
      .jmp_ID(jmp_ID), .jmp_target_ID(jmp_target_ID),
      .ld_use_stall(ld_use_stall), .i_ready(i_ready),
      .pc_cmd_EX(pc_cmd_EX), .pc_cmd_ID(pc_cmd_ID),
      .pc_in_EX(pc_in_EX), .pc_in_ID(pc_in_ID),
      .pc_hold(pc_hold), .i_req(i_req), .stall_IFID(stall_IFID),
      .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .squash_cnt(squash_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic br, input logic [31:0] bt, input logic ld,
                        input logic j, input logic [31:0] jt, input logic rdy);
      br_take_EX = br; br_target_EX = bt; ld_use_stall = ld;
      jmp_ID = j; jmp_target_ID = jt; i_ready = rdy;
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(1, 32'h44, 0, 1, 32'h88, 0);
      checks++; if (i_req !== 1'b0) begin errors++; $display("FAIL rst_ireq: got %b exp 0", i_req); end
      checks++; if ({pc_cmd_EX, pc_cmd_ID, pc_hold, flush_IFID, flush_IDEX} !== 5'b0) begin errors++; $display("FAIL rst_ctrl: got %b exp 00000", {pc_cmd_EX, pc_cmd_ID, pc_hold, flush_IFID, flush_IDEX}); end
      tick();
      reset_n = 1'b1;
      drive(0, 0, 0, 0, 0, 1);
      checks++; if (i_req !== 1'b1) begin errors++; $display("FAIL run_ireq: got %b exp 1", i_req); end
      checks++; if ({pc_cmd_EX, pc_cmd_ID, pc_hold, stall_IFID, flush_IFID, flush_IDEX} !== 6'b0) begin errors++; $display("FAIL run_idle: got %b exp 000000", {pc_cmd_EX, pc_cmd_ID, pc_hold, stall_IFID, flush_IFID, flush_IDEX}); end
      checks++; if (squash_cnt !== 16'd0) begin errors++; $display("FAIL run_cnt: got %0d exp 0", squash_cnt); end
   endtask

   task automatic test_branch_priority();
      do_reset();
      drive(1, 32'h40, 0, 1, 32'h99, 1);
      checks++; if ({pc_cmd_EX, pc_cmd_ID} !== 2'b10) begin errors++; $display("FAIL br_cmd: got %b exp 10", {pc_cmd_EX, pc_cmd_ID}); end
      checks++; if (pc_in_EX !== 32'h40) begin errors++; $display("FAIL br_target: got %h exp 00000040", pc_in_EX); end
      checks++; if ({flush_IFID, flush_IDEX} !== 2'b11) begin errors++; $display("FAIL br_flush: got %b exp 11", {flush_IFID, flush_IDEX}); end
      tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++; if (squash_cnt !== 16'd2) begin errors++; $display("FAIL br_cnt: got %0d exp 2", squash_cnt); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(0, 0, 1, 1, 32'h80, 1);
      checks++; if ({pc_hold, stall_IFID, flush_IDEX, flush_IFID, pc_cmd_ID} !== 5'b11100) begin errors++; $display("FAIL ld_stall: got %b exp 11100", {pc_hold, stall_IFID, flush_IDEX, flush_IFID, pc_cmd_ID}); end
      tick();
      drive(0, 0, 0, 1, 32'h80, 1);
      checks++; if ({pc_cmd_ID, flush_IFID, pc_hold} !== 3'b110) begin errors++; $display("FAIL ld_jump: got %b exp 110", {pc_cmd_ID, flush_IFID, pc_hold}); end
      checks++; if (pc_in_ID !== 32'h80) begin errors++; $display("FAIL ld_jtarget: got %h exp 00000080", pc_in_ID); end
      tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++; if (squash_cnt !== 16'd1) begin errors++; $display("FAIL ld_cnt: got %0d exp 1", squash_cnt); end
   endtask

   task automatic test_captured_jump();
      do_reset();
      drive(0, 0, 0, 1, 32'h100, 0);
      checks++; if ({pc_cmd_ID, pc_cmd_EX, flush_IFID, pc_hold} !== 4'b0011) begin errors++; $display("FAIL cap_run: got %b exp 0011", {pc_cmd_ID, pc_cmd_EX, flush_IFID, pc_hold}); end
      for (int c = 0; c < 2; c++) begin
         tick();
         drive(0, 0, 0, 0, 0, 0);
         checks++; if ({i_req, flush_IFID, pc_hold, pc_cmd_EX} !== 4'b1110) begin errors++; $display("FAIL cap_pend%0d: got %b exp 1110", c, {i_req, flush_IFID, pc_hold, pc_cmd_EX}); end
      end
      tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++; if ({flush_IFID, pc_hold, pc_cmd_EX} !== 3'b110) begin errors++; $display("FAIL cap_exit: got %b exp 110", {flush_IFID, pc_hold, pc_cmd_EX}); end
      tick();
      checks++; if ({pc_cmd_EX, pc_cmd_ID, i_req, flush_IFID, pc_hold} !== 5'b10100) begin errors++; $display("FAIL cap_issue: got %b exp 10100", {pc_cmd_EX, pc_cmd_ID, i_req, flush_IFID, pc_hold}); end
      checks++; if (pc_in_EX !== 32'h100) begin errors++; $display("FAIL cap_target: got %h exp 00000100", pc_in_EX); end
      tick();
      checks++; if (pc_cmd_EX !== 1'b0) begin errors++; $display("FAIL cap_oneshot: got %b exp 0", pc_cmd_EX); end
      checks++; if (squash_cnt !== 16'd2) begin errors++; $display("FAIL cap_cnt: got %0d exp 2", squash_cnt); end
   endtask

   task automatic test_pend_ignores();
      do_reset();
      drive(1, 32'h300, 0, 0, 0, 0);
      checks++; if ({flush_IFID, flush_IDEX, pc_hold, pc_cmd_EX} !== 4'b1110) begin errors++; $display("FAIL pi_capture: got %b exp 1110", {flush_IFID, flush_IDEX, pc_hold, pc_cmd_EX}); end
      tick();
      drive(1, 32'h200, 1, 1, 32'h55, 0);
      checks++; if ({flush_IFID, flush_IDEX, stall_IFID, pc_cmd_EX, pc_cmd_ID} !== 5'b10000) begin errors++; $display("FAIL pi_pend: got %b exp 10000", {flush_IFID, flush_IDEX, stall_IFID, pc_cmd_EX, pc_cmd_ID}); end
      tick();
      drive(0, 0, 0, 0, 0, 1);
      tick();
      checks++; if (pc_in_EX !== 32'h300) begin errors++; $display("FAIL pi_target: got %h exp 00000300", pc_in_EX); end
      tick();
      checks++; if (squash_cnt !== 16'd3) begin errors++; $display("FAIL pi_cnt: got %0d exp 3", squash_cnt); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      drive(1, 32'h44, 1, 1, 32'h66, 0);
      checks++; if ({pc_cmd_EX, pc_cmd_ID, flush_IFID, flush_IDEX, stall_IFID, pc_hold} !== 6'b001101) begin errors++; $display("FAIL sim_run: got %b exp 001101", {pc_cmd_EX, pc_cmd_ID, flush_IFID, flush_IDEX, stall_IFID, pc_hold}); end
      tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++; if (squash_cnt !== 16'd2) begin errors++; $display("FAIL sim_cnt: got %0d exp 2", squash_cnt); end
      tick();
      checks++; if ({pc_cmd_EX, pc_in_EX} !== {1'b1, 32'h44}) begin errors++; $display("FAIL sim_issue: got %b/%h exp 1/00000044", pc_cmd_EX, pc_in_EX); end
   endtask

   task automatic test_saturate();
      do_reset();
      drive(1, 32'h10, 0, 0, 0, 1);
      repeat (32767) tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++; if (squash_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h exp fffe", squash_cnt); end
      drive(1, 32'h10, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++; if (squash_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_br: got %h exp ffff", squash_cnt); end
      drive(0, 0, 0, 1, 32'h20, 1);
      tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++; if (squash_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_jmp: got %h exp ffff", squash_cnt); end
   endtask

   task automatic test_reset_in_pend();
      drive(0, 0, 0, 1, 32'h500, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      #1;
      reset_n = 1'b0;
      #1;
      checks++; if (squash_cnt !== 16'd0) begin errors++; $display("FAIL rp_cnt: got %h exp 0000", squash_cnt); end
      checks++; if ({i_req, flush_IFID, pc_hold} !== 3'b000) begin errors++; $display("FAIL rp_out: got %b exp 000", {i_req, flush_IFID, pc_hold}); end
      tick();
      reset_n = 1'b1;
      drive(0, 0, 0, 0, 0, 1);
      checks++; if ({flush_IFID, pc_hold, pc_cmd_EX} !== 3'b000) begin errors++; $display("FAIL rp_run: got %b exp 000", {flush_IFID, pc_hold, pc_cmd_EX}); end
      tick();
      checks++; if (pc_cmd_EX !== 1'b0) begin errors++; $display("FAIL rp_noissue: got %b exp 0", pc_cmd_EX); end
   endtask

   initial begin
      test_reset();
      test_branch_priority();
      test_load_use();
      test_captured_jump();
      test_pend_ignores();
      test_simultaneous();
      test_saturate();
      test_reset_in_pend();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
